alu_result_queue: RTL and testbench
===================================

Name: alu_result_queue

Overview:
- Registered output buffer placed directly downstream of the ALU shift/logic units.
- Captures each combinational result word with its Z/N flags into a small first-word-fall-through FIFO, using a valid/ready handshake.
- Maintains the architectural status register (Z, N), which is updated when a result is consumed by writeback.
- Breaks the combinational path from ALU output to the register file.

Parameters:
- DATA_W, 32, width of result word
- DEPTH, 4, number of FIFO entries; power of two, minimum 2
- CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  ALU presents a result this cycle
- in_ready  output  1  queue can accept a result this cycle
- in_result  input  DATA_W  ALU result word (shifter B output)
- in_z  input  1  ALU zero flag
- in_n  input  1  ALU negative flag
- out_valid  output  1  head entry is available
- out_ready  input  1  writeback consumes the head this cycle
- out_result  output  DATA_W  head result word
- out_z  output  1  head zero flag
- out_n  output  1  head negative flag
- status_z  output  1  architectural Z, last consumed result
- status_n  output  1  architectural N, last consumed result
- count  output  CNT_W  current occupancy, 0..DEPTH
- flag_err  output  1  sticky flag-consistency error (see Optional Feature)

Behaviour:
- Reset (rst=1 at clk edge) has priority over all other activity:
  - Pointers, count, status_z, status_n and flag_err are cleared to 0.
  - All storage entries are cleared to 0, so out_result=0, out_z=0, out_n=0 and out_valid=0 after reset.
  - Entries in flight when reset is asserted mid-operation are discarded.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH). It does not depend on out_ready, so there is no combinational ready path.
  - out_valid = (count != 0).
- Storage: circular buffer with rd_ptr and wr_ptr of width $clog2(DEPTH), wrapping from DEPTH-1 to 0.
- Push writes {in_result, in_z, in_n} at wr_ptr, then wr_ptr increments.
- Pop increments rd_ptr.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together, with 0<count<DEPTH: count unchanged, both pointers advance.
  - When empty, only a push can occur.
  - When full, only a pop can occur, because in_ready=0.
- Latency: a result pushed into an empty queue appears on out_* with out_valid=1 on the next cycle. There is no same-cycle bypass.
- Outputs out_result/out_z/out_n are driven combinationally from the entry at rd_ptr. They are meaningful only while out_valid=1 and are held stable while out_valid=1 and out_ready=0.
- Status register:
  - On pop, status_z and status_n load the popped out_z and out_n at the clock edge.
  - Without a pop, status_z and status_n hold their values.
- in_valid while full: the result is not accepted and the producer must hold it. No error is raised.
- Data and flags are stored as received. The queue does no arithmetic; Z/N semantics are: Z=1 iff result==0, N=result[DATA_W-1].

Optional Feature:
- Macro: ALU_FLAG_RECHECK_EN.
- Defined:
  - On each push, the queue recomputes z_chk=(in_result==0) and n_chk=in_result[DATA_W-1].
  - If {in_z,in_n} != {z_chk,n_chk}, flag_err is set to 1 on that edge and stays set until rst.
  - The stored flags are the recomputed values, not the inputs.
- Undefined:
  - No check logic is built and flag_err is tied to 0.
  - Stored flags are in_z/in_n unchanged.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0, status_z=0, status_n=0, flag_err=0.
- Push {32'h00000010,z=0,n=0} with out_ready=0 -> next cycle out_valid=1, out_result=32'h10, count=1. Assert out_ready for one cycle -> count=0, status_z=0, status_n=0.
- Push 4 results 32'h1, 32'h0 (z=1), 32'h80000000 (n=1), 32'h2 with out_ready=0 -> count=4, in_ready=0. A held 5th push is not accepted. Pop all 4 -> data returned in order, status ends z=0,n=0; after the 2nd pop status_z=1, after the 3rd pop status_n=1.
- Count 2, simultaneous push and pop for 6 cycles -> count stays 2, pointers wrap past 3, data order preserved.
- Count 3, assert rst for one cycle during an active push -> next cycle count=0, out_valid=0, status cleared, the pushed word is lost.
- With ALU_FLAG_RECHECK_EN: push 32'h0 with z=0 -> flag_err=1 and stays 1; the popped entry shows out_z=1. Without the macro: same push -> flag_err=0, out_z=0.

Source files
------------

// File: rtl/alu_result_queue.sv
// Registered FWFT result queue between the ALU and writeback, also holding the architectural Z/N status.
// Optional build macro ALU_FLAG_RECHECK_EN recomputes flags on entry and raises a sticky flag_err on mismatch.
module alu_result_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_z,
  input  logic              in_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_z,
  output logic              out_n,
  output logic              status_z,
  output logic              status_n,
  output logic [CNT_W-1:0]  count,
  output logic              flag_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_result [DEPTH];
  logic [DEPTH-1:0]  mem_z;
  logic [DEPTH-1:0]  mem_n;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic              store_z;
  logic              store_n;

  // Ready depends only on occupancy, so no combinational path from out_ready.
  assign in_ready   = (count != CNT_W'(DEPTH));
  assign out_valid  = (count != '0);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign out_result = mem_result[rd_ptr];
  assign out_z      = mem_z[rd_ptr];
  assign out_n      = mem_n[rd_ptr];

`ifdef ALU_FLAG_RECHECK_EN
  logic flag_mismatch;

  // Stored flags come from the result itself; the ALU's flags are only compared.
  always_comb begin
    store_z       = (in_result == '0);
    store_n       = in_result[DATA_W-1];
    flag_mismatch = push & ({in_z, in_n} != {store_z, store_n});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_err <= 1'b0;
    end else if (flag_mismatch) begin
      flag_err <= 1'b1;
    end
  end
`else
  assign store_z  = in_z;
  assign store_n  = in_n;
  assign flag_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i] <= '0;
      end
      mem_z <= '0;
      mem_n <= '0;
    end else if (push) begin
      mem_result[wr_ptr] <= in_result;
      mem_z[wr_ptr]      <= store_z;
      mem_n[wr_ptr]      <= store_n;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the wrap to entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_z <= 1'b0;
      status_n <= 1'b0;
    end else if (pop) begin
      status_z <= out_z;
      status_n <= out_n;
    end
  end

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: a queue-based reference model checked every cycle plus literal spot checks.
module tb_alu_result_queue;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_z;
  logic              in_n;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_z;
  logic              out_n;
  logic              status_z;
  logic              status_n;
  logic [CNT_W-1:0]  count;
  logic              flag_err;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              z;
    logic              n;
  } entry_t;

  entry_t model_q[$];
  logic   model_sz;
  logic   model_sn;
  logic   model_err;
  bit     model_live = 0;
  int     pass_cnt = 0;
  int     check_cnt = 0;

  alu_result_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_z(in_z), .in_n(in_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_z(out_z), .out_n(out_n),
    .status_z(status_z), .status_n(status_n), .count(count), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: a plain FIFO of entries plus the last-consumed flags.
  always @(posedge clk) begin
    entry_t e;
    bit do_push;
    bit do_pop;
    model_live = 1;
    if (rst) begin
      model_q.delete();
      model_sz  = 0;
      model_sn  = 0;
      model_err = 0;
    end else begin
      do_push = in_valid && (model_q.size() < DEPTH);
      do_pop  = out_ready && (model_q.size() > 0);
      if (do_pop) begin
        e = model_q.pop_front();
        model_sz = e.z;
        model_sn = e.n;
      end
      if (do_push) begin
        e.data = in_result;
`ifdef ALU_FLAG_RECHECK_EN
        e.z = (in_result == 0);
        e.n = in_result[DATA_W-1];
        if (e.z != in_z || e.n != in_n) model_err = 1;
`else
        e.z = in_z;
        e.n = in_n;
`endif
        model_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      checkOutput("in_ready", 64'(in_ready), 64'(model_q.size() != DEPTH));
      checkOutput("count", 64'(count), 64'(model_q.size()));
      checkOutput("status_z", 64'(status_z), 64'(model_sz));
      checkOutput("status_n", 64'(status_n), 64'(model_sn));
      checkOutput("flag_err", 64'(flag_err), 64'(model_err));
      if (model_q.size() != 0) begin
        checkOutput("out_result", 64'(out_result), 64'(model_q[0].data));
        checkOutput("out_z", 64'(out_z), 64'(model_q[0].z));
        checkOutput("out_n", 64'(out_n), 64'(model_q[0].n));
      end
    end
  end

  // Drive one cycle of inputs, let the edge happen, then settle just after it.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic z,
                               input logic n, input logic ordy, input logic r);
    in_valid  = v;
    in_result = d;
    in_z      = z;
    in_n      = n;
    out_ready = ordy;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 0; in_result = '0; in_z = 0; in_n = 0; out_ready = 0; rst = 1;
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset count", 64'(count), 64'd0);
    checkOutput("reset status", 64'({status_z, status_n}), 64'd0);
    checkOutput("reset flag_err", 64'(flag_err), 64'd0);
    checkOutput("reset out_result", 64'(out_result), 64'd0);

    applyStimulus(1, 32'h10, 0, 0, 0, 0);
    checkOutput("single out_valid", 64'(out_valid), 64'd1);
    checkOutput("single out_result", 64'(out_result), 64'h10);
    checkOutput("single count", 64'(count), 64'd1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("single drained count", 64'(count), 64'd0);
    checkOutput("single status", 64'({status_z, status_n}), 64'd0);

    applyStimulus(1, 32'h1, 0, 0, 0, 0);
    applyStimulus(1, 32'h0, 1, 0, 0, 0);
    applyStimulus(1, 32'h80000000, 0, 1, 0, 0);
    applyStimulus(1, 32'h2, 0, 0, 0, 0);
    checkOutput("full count", 64'(count), 64'd4);
    checkOutput("full in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1, 32'h5, 0, 0, 0, 0);
    applyStimulus(1, 32'h5, 0, 0, 0, 0);
    checkOutput("held push count", 64'(count), 64'd4);
    checkOutput("pop1 head", 64'(out_result), 64'h1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("pop1 status", 64'({status_z, status_n}), 64'b00);
    checkOutput("pop2 head", 64'(out_result), 64'h0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("pop2 status", 64'({status_z, status_n}), 64'b10);
    checkOutput("pop3 head", 64'(out_result), 64'h80000000);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("pop3 status", 64'({status_z, status_n}), 64'b01);
    checkOutput("pop4 head", 64'(out_result), 64'h2);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("pop4 status", 64'({status_z, status_n}), 64'b00);
    checkOutput("drained count", 64'(count), 64'd0);

    applyStimulus(1, 32'hA0, 0, 0, 0, 0);
    applyStimulus(1, 32'hA1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 32'h100 + i, 0, 0, 1, 0);
      checkOutput("stream count", 64'(count), 64'd2);
    end
    checkOutput("stream head", 64'(out_result), 64'h104);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    applyStimulus(1, 32'h0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("pre-reset status_z", 64'(status_z), 64'd1);
    applyStimulus(1, 32'h11, 0, 0, 0, 0);
    applyStimulus(1, 32'h12, 0, 0, 0, 0);
    applyStimulus(1, 32'h13, 0, 0, 0, 0);
    checkOutput("pre-reset count", 64'(count), 64'd3);
    applyStimulus(1, 32'hDEAD, 0, 0, 0, 1);
    checkOutput("mid reset count", 64'(count), 64'd0);
    checkOutput("mid reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid reset status", 64'({status_z, status_n}), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post reset count", 64'(count), 64'd0);

    applyStimulus(1, 32'h0, 0, 0, 0, 0);
`ifdef ALU_FLAG_RECHECK_EN
    checkOutput("recheck flag_err", 64'(flag_err), 64'd1);
    checkOutput("recheck out_z", 64'(out_z), 64'd1);
`else
    checkOutput("recheck flag_err", 64'(flag_err), 64'd0);
    checkOutput("recheck out_z", 64'(out_z), 64'd0);
`endif
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
`ifdef ALU_FLAG_RECHECK_EN
    checkOutput("sticky flag_err", 64'(flag_err), 64'd1);
`else
    checkOutput("sticky flag_err", 64'(flag_err), 64'd0);
`endif

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
